// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Used by imem_arbiter and its statistics option (IMEM_ARB_STATS_EN).
package imem_arb_pkg;

  typedef enum logic {
    PRIO_FETCH = 1'b0,
    PRIO_DBG   = 1'b1
  } prio_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied debug cycles; hit flags the cycle
// whose denial brings the count to STARVE_LIMIT.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Looks ahead so priority flips on the same edge the count reaches the limit.
  assign hit = inc & ~clr & (cnt >= (LIMIT - 1'b1));

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/debug arbiter for the single-ported synchronous instruction ROM.
// Optional grant statistics enabled by defining IMEM_ARB_STATS_EN.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int A_WIDTH      = 8,
  parameter int I_WIDTH      = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_req_i,
  input  logic [A_WIDTH-1:0] f_addr_i,
  input  logic               f_flush_i,
  output logic               f_gnt_o,
  output logic               f_rvalid_o,
  output logic [I_WIDTH-1:0] f_rdata_o,
  input  logic               d_req_i,
  input  logic [A_WIDTH-1:0] d_addr_i,
  output logic               d_gnt_o,
  output logic               d_rvalid_o,
  output logic [I_WIDTH-1:0] d_rdata_o,
  output logic               mem_en_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  input  logic [I_WIDTH-1:0] mem_data_i
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  f_gnt_cnt_o,
  output logic [STAT_W-1:0]  d_gnt_cnt_o
`endif
);

  prio_e  state;
  owner_e owner_p1;
  logic   f_gnt;
  logic   d_gnt;
  logic   starve_inc;
  logic   starve_hit;

  // Grants are combinational; forced low while reset is asserted.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (state == PRIO_DBG) begin
        d_gnt = d_req_i;
        f_gnt = f_req_i & ~f_flush_i & ~d_req_i;
      end else begin
        f_gnt = f_req_i & ~f_flush_i;
        d_gnt = d_req_i & ~f_gnt;
      end
    end
  end

  assign f_gnt_o    = f_gnt;
  assign d_gnt_o    = d_gnt;
  assign mem_en_o   = f_gnt | d_gnt;
  assign mem_addr_o = f_gnt ? f_addr_i : (d_gnt ? d_addr_i : '0);

  assign starve_inc = d_req_i & ~d_gnt;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (starve_inc),
    .clr  (~starve_inc),
    .hit  (starve_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRIO_FETCH;
      owner_p1 <= OWN_NONE;
    end else begin
      case (state)
        PRIO_FETCH: if (starve_hit) state <= PRIO_DBG;
        PRIO_DBG:   if (d_gnt)      state <= PRIO_FETCH;
        default:                    state <= PRIO_FETCH;
      endcase
      owner_p1 <= f_gnt ? OWN_FETCH : (d_gnt ? OWN_DBG : OWN_NONE);
    end
  end

  // Read-data stage: ROM output routed to the owner of last cycle's grant.
  assign f_rvalid_o = (owner_p1 == OWN_FETCH) & ~f_flush_i;
  assign d_rvalid_o = (owner_p1 == OWN_DBG);
  assign f_rdata_o  = f_rvalid_o ? mem_data_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_data_i : '0;

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_gnt_cnt_o <= '0;
      d_gnt_cnt_o <= '0;
    end else begin
      if (f_gnt) f_gnt_cnt_o <= f_gnt_cnt_o + 1'b1;
      if (d_gnt) d_gnt_cnt_o <= d_gnt_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single-ported, synchronous-read instruction ROM between the fetch unit and a debug/loader read port. Fetch has priority. A starvation counter guarantees that a waiting debug read is served within a bounded number of cycles. Each grant issues exactly one ROM read, and its data is returned to the owning requester one cycle later. The block sits between the fetch unit's PC/mux datapath and the ROM instance.

## Interface
- A_WIDTH, 8: ROM address width.
- I_WIDTH, 12: instruction width.
- STARVE_LIMIT, 4: consecutive denied debug-request cycles before debug gets priority; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- f_req_i  in  1  fetch read request.
- f_addr_i  in  A_WIDTH  fetch read address.
- f_flush_i  in  1  fetch restart; kills the pending fetch response.
- f_gnt_o  out  1  fetch request accepted this cycle.
- f_rvalid_o  out  1  fetch read data valid.
- f_rdata_o  out  I_WIDTH  fetch read data.
- d_req_i  in  1  debug read request.
- d_addr_i  in  A_WIDTH  debug read address.
- d_gnt_o  out  1  debug request accepted this cycle.
- d_rvalid_o  out  1  debug read data valid.
- d_rdata_o  out  I_WIDTH  debug read data.
- mem_en_o  out  1  ROM read enable.
- mem_addr_o  out  A_WIDTH  ROM address.
- mem_data_i  in  I_WIDTH  ROM output; valid one cycle after the address is sampled.

## Operation
- States: PRIO_FETCH (reset state) and PRIO_DBG.

PRIO_FETCH:
- f_gnt_o = f_req_i & ~f_flush_i.
- d_gnt_o = d_req_i & ~f_gnt_o.

PRIO_DBG:
- d_gnt_o = d_req_i.
- f_gnt_o = f_req_i & ~f_flush_i & ~d_req_i.

Addressing and responses:
- mem_en_o = f_gnt_o | d_gnt_o.
- mem_addr_o = address of the granted requester; 0 when there is no grant.
- A registered owner tag (NONE/FETCH/DBG) records each grant.
- Next cycle, the owner's rvalid asserts. Its rdata = mem_data_i; rdata is 0 when rvalid is low.

Starvation counter, width clog2(STARVE_LIMIT+1):
- Increments on cycles with d_req_i & ~d_gnt_o, saturating at STARVE_LIMIT.
- Clears on d_gnt_o or on ~d_req_i.
- Reaching STARVE_LIMIT moves PRIO_FETCH→PRIO_DBG.
- A debug grant in PRIO_DBG returns to PRIO_FETCH.

Requester rules:
- Requester holds req and addr stable until it sees gnt.
- A requester may re-request in the cycle after gnt (back-to-back reads, one per cycle).

Boundary cases:
- f_flush_i in cycle c: blocks a fetch grant in c and suppresses the fetch response due in c (the response to a c-1 grant). The debug path is unaffected.
- Simultaneous requests in PRIO_FETCH: fetch wins and the debug counter increments.
- d_req_i dropped while in PRIO_DBG: the state stays PRIO_DBG until the next debug grant.
- Reset mid-read: the pending response is discarded and no rvalid follows.

## Timing
- Grants are combinational (Mealy) from requests and state; there is no grant latency.
- Read latency is 1 cycle: grant in cycle c gives rvalid/rdata in cycle c+1.
- Throughput: 1 read per cycle total.
- Worst-case debug wait from first request: STARVE_LIMIT+1 cycles.

Reset values:
- All outputs 0.
- State PRIO_FETCH, owner tag NONE, counter 0.

## Configuration
- IMEM_ARB_STATS_EN defined: adds outputs f_gnt_cnt_o and d_gnt_cnt_o (16 bits each, wrap at 0xFFFF→0). Each counts that port's grants; reset 0.
- IMEM_ARB_STATS_EN undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Package imem_arb_pkg holds:
  - the state enum (PRIO_FETCH, PRIO_DBG);
  - the owner enum (OWN_NONE, OWN_FETCH, OWN_DBG);
  - the statistics counter width constant (16).
- One sub-module, arb_starve_ctr: saturating counter with inc/clear inputs and a limit-reached output, parameterized by STARVE_LIMIT.

## Test plan
- Reset with f_req_i=1, f_addr_i=0x10 held: all outputs 0 during reset. First edge after release gives f_gnt_o=1, mem_addr_o=0x10. Next cycle f_rvalid_o=1 and f_rdata_o equals ROM[0x10].
- Continuous fetch requests plus d_req_i=1, d_addr_i=0x80, STARVE_LIMIT=4: d_gnt_o=0 for 4 cycles, then 1 in the 5th. The ROM[0x80] response appears on d_rdata_o only, and fetch resumes the next cycle.
- Fetch grant at 0x20 in cycle c, f_flush_i=1 in c+1: f_rvalid_o stays 0 in c+1 and f_gnt_o=0 in c+1. Unflushed fetch at 0x05 in c+2 returns ROM[0x05] in c+3.
- Alternating fetch 0x01 and debug 0x02 single requests: each rvalid fires exactly once, on the correct port. The other port's rdata stays 0.
- rst_n asserted in the cycle after a debug grant: d_rvalid_o remains 0 and the owner tag is NONE after release.
- Build with IMEM_ARB_STATS_EN, 3 fetch and 2 debug grants: f_gnt_cnt_o=3 and d_gnt_cnt_o=2. After 65536 fetch grants, f_gnt_cnt_o wraps to the expected value.
